// File: rtl/h80_uart_pkg.sv
// Shared constants for the h80 UART receive path and its I/O bus slave.
package h80_uart_pkg;

    localparam int unsigned H80_UART_RX_DEPTH_DEFAULT = 16;

    localparam int unsigned ST_RX_READY = 0;
    localparam int unsigned ST_FULL     = 1;
    localparam int unsigned ST_OVERFLOW = 2;
    localparam int unsigned ST_BREAK    = 3;

    localparam logic [15:0] UART_DATA   = 16'h0000;
    localparam logic [15:0] UART_STATUS = 16'h0001;

endpackage

// File: rtl/h80_fifo_ram.sv
// DEPTH x 8 simple dual-port storage: synchronous write, asynchronous read.
module h80_fifo_ram
    import h80_uart_pkg::*;
#(
    parameter int unsigned DEPTH = H80_UART_RX_DEPTH_DEFAULT,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              sysclk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge sysclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/h80_uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the h80 bus slave.
// Optional H80_UART_RX_BREAK_FLUSH_EN: rx_break flushes the FIFO and sets break_seen.
module h80_uart_rx_fifo
    import h80_uart_pkg::*;
#(
    parameter int unsigned DEPTH = H80_UART_RX_DEPTH_DEFAULT,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_break,
    input  logic              pop,
    input  logic              ovf_clear,
    output logic [7:0]        rd_data,
    output logic              rx_ready,
    output logic              full,
    output logic              overflow,
    output logic [ADDR_W:0]   count,
    output logic [7:0]        status
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              ovf_q;
    logic              break_seen;
    logic              flush;
    logic              push_ok;
    logic              pop_ok;
    logic              ovf_event;
    logic [7:0]        ram_rdata;

    assign full      = (cnt == FULL_COUNT);
    assign rx_ready  = (cnt != '0);
    // A pop at full frees the slot the same cycle, so the push is still taken.
    assign push_ok   = rx_valid && (!full || pop);
    assign pop_ok    = pop && (cnt != '0);
    assign ovf_event = rx_valid && full && !pop;

`ifdef H80_UART_RX_BREAK_FLUSH_EN
    assign flush = rx_break;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            break_seen <= 1'b0;
        end else if (rx_break) begin
            break_seen <= 1'b1;
        end else if (ovf_clear) begin
            break_seen <= 1'b0;
        end
    end
`else
    logic unused_break;

    assign unused_break = rx_break;
    assign flush        = 1'b0;
    assign break_seen   = 1'b0;
`endif

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
                case ({push_ok, pop_ok})
                    2'b10:   cnt <= cnt + (ADDR_W+1)'(1);
                    2'b01:   cnt <= cnt - (ADDR_W+1)'(1);
                    default: cnt <= cnt;
                endcase
            end
            if (ovf_event) begin
                ovf_q <= 1'b1;
            end else if (ovf_clear) begin
                ovf_q <= 1'b0;
            end
        end
    end

    h80_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .sysclk (sysclk),
        .we     (push_ok && !flush),
        .waddr  (wr_ptr),
        .wdata  (rx_data),
        .raddr  (rd_ptr),
        .rdata  (ram_rdata)
    );

    assign rd_data  = (cnt == '0) ? 8'h00 : ram_rdata;
    assign overflow = ovf_q;
    assign count    = cnt;

    always_comb begin
        status              = '0;
        status[ST_RX_READY] = rx_ready;
        status[ST_FULL]     = full;
        status[ST_OVERFLOW] = ovf_q;
        status[ST_BREAK]    = break_seen;
    end

endmodule

// File: tb/tb_h80_uart_rx_fifo.sv
// Directed self-checking bench for h80_uart_rx_fifo (DEPTH = 16).
module tb_h80_uart_rx_fifo;

    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_break = 1'b0;
    logic       pop = 1'b0;
    logic       ovf_clear = 1'b0;
    logic [7:0] rd_data;
    logic       rx_ready;
    logic       full;
    logic       overflow;
    logic [4:0] count;
    logic [7:0] status;

    int n_tests = 0;
    int n_fail  = 0;

    h80_uart_rx_fifo #(
        .DEPTH (16)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_break  (rx_break),
        .pop       (pop),
        .ovf_clear (ovf_clear),
        .rd_data   (rd_data),
        .rx_ready  (rx_ready),
        .full      (full),
        .overflow  (overflow),
        .count     (count),
        .status    (status)
    );

    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pop_one();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); end
        n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
        n_tests++; if (status !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h expected 00", status); end
        // push and pop during the reset cycle are ignored
        reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h99; pop = 1'b1;
        tick();
        reset = 1'b0; rx_valid = 1'b0; pop = 1'b0;
        n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_ignores_push: got %0d expected 0", count); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        do_reset();
        push(8'h41);
        n_tests++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_latency: got %b expected 1", rx_ready); end
        n_tests++; if (rd_data !== 8'h41) begin n_fail++; $display("FAIL basic_head_latency: got %h expected 41", rd_data); end
        push(8'h42);
        push(8'h43);
        n_tests++; if (count !== 5'd3) begin n_fail++; $display("FAIL basic_count3: got %0d expected 3", count); end
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (rd_data !== exp_b[i]) begin n_fail++; $display("FAIL basic_pop%0d: got %h expected %h", i, rd_data, exp_b[i]); end
            pop_one();
        end
        n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL basic_empty_data: got %h expected 00", rd_data); end
        n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL basic_empty_ready: got %b expected 0", rx_ready); end
        n_tests++; if (status !== 8'h00) begin n_fail++; $display("FAIL basic_empty_status: got %h expected 00", status); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(i));
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", full); end
        n_tests++; if (status !== 8'h03) begin n_fail++; $display("FAIL fill_status: got %h expected 03", status); end
        push(8'hAA);
        n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d expected 16", count); end
        n_tests++; if (status !== 8'h07) begin n_fail++; $display("FAIL ovf_status: got %h expected 07", status); end
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL ovf_drain%0d: got %h expected %h", i, rd_data, 8'(i)); end
            pop_one();
        end
        n_tests++; if (status !== 8'h04) begin n_fail++; $display("FAIL ovf_sticky_status: got %h expected 04", status); end
        ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        rx_valid = 1'b1; rx_data = 8'h55; pop = 1'b1;
        tick();
        rx_valid = 1'b0; pop = 1'b0;
        n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL pp_full_count: got %0d expected 16", count); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_full_ovf: got %b expected 0", overflow); end
        for (int i = 1; i < 16; i++) begin
            n_tests++; if (rd_data !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL pp_drain%0d: got %h expected %h", i, rd_data, 8'(8'h10 + i)); end
            pop_one();
        end
        n_tests++; if (rd_data !== 8'h55) begin n_fail++; $display("FAIL pp_wrap_last: got %h expected 55", rd_data); end
        pop_one();
        n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL pp_final_count: got %0d expected 0", count); end
    endtask

    task automatic test_pop_empty();
        do_reset();
        pop_one();
        n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL pe_count: got %0d expected 0", count); end
        n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL pe_data: got %h expected 00", rd_data); end
        // simultaneous push/pop on empty: only the push takes effect
        rx_valid = 1'b1; rx_data = 8'h5A; pop = 1'b1;
        tick();
        rx_valid = 1'b0; pop = 1'b0;
        n_tests++; if (count !== 5'd1) begin n_fail++; $display("FAIL pe_pp_count: got %0d expected 1", count); end
        n_tests++; if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL pe_pp_data: got %h expected 5A", rd_data); end
        pop_one();
        n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL pe_final_count: got %0d expected 0", count); end
    endtask

    task automatic test_ovf_clear_same_cycle();
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
        rx_valid = 1'b1; rx_data = 8'hEE; ovf_clear = 1'b1;
        tick();
        rx_valid = 1'b0; ovf_clear = 1'b0;
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovfsame_set_wins: got %b expected 1", overflow); end
        ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovfsame_clear: got %b expected 0", overflow); end
        n_tests++; if (rd_data !== 8'hC0) begin n_fail++; $display("FAIL ovfsame_head: got %h expected C0", rd_data); end
    endtask

    task automatic test_break();
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        rx_break = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
        tick();
        rx_break = 1'b0; rx_valid = 1'b0;
`ifdef H80_UART_RX_BREAK_FLUSH_EN
        n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL brk_count: got %0d expected 0", count); end
        n_tests++; if (status !== 8'h08) begin n_fail++; $display("FAIL brk_status: got %h expected 08", status); end
        push(8'h31);
        n_tests++; if (rd_data !== 8'h31) begin n_fail++; $display("FAIL brk_next_data: got %h expected 31", rd_data); end
        ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
        n_tests++; if (status !== 8'h01) begin n_fail++; $display("FAIL brk_clear_status: got %h expected 01", status); end
`else
        n_tests++; if (count !== 5'd6) begin n_fail++; $display("FAIL brk_ignored_count: got %0d expected 6", count); end
        n_tests++; if (status !== 8'h01) begin n_fail++; $display("FAIL brk_ignored_status: got %h expected 01", status); end
        n_tests++; if (rd_data !== 8'h60) begin n_fail++; $display("FAIL brk_ignored_head: got %h expected 60", rd_data); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_push_pop_full();
        test_pop_empty();
        test_ovf_clear_same_cycle();
        test_break();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
